dac_frame_rx: RTL and testbench
===============================

Name: dac_frame_rx

Overview:
- Receive-side counterpart of the two-lane DAC serial writer.
- Oversamples the frame interface (sclk, active-low sync, two data lanes) on the 200 MHz system clock.
- Deserialises one WORD_BITS word per lane per frame, MSB first, and flags malformed frames.
- Used as a loopback checker/monitor on the DAC bus and as the front end for boards that send frames in the same format.

Parameters:
- WORD_BITS, 16, bits per frame per lane.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (min 2).
- SAMPLE_FALLING, 1: data sampled on sclk falling edge; 0: on rising edge.

Ports:
- clk  input  1  system clock, 200 MHz.
- rst_n  input  1  reset; synchronous, active-low.
- sclk_in  input  1  serial clock from the transmitter, asynchronous to clk.
- sync_in  input  1  frame strobe, active-low.
- din_in  input  1  data lane 0.
- din_1_in  input  1  data lane 1.
- data0  output  WORD_BITS  last complete lane-0 word.
- data1  output  WORD_BITS  last complete lane-1 word.
- data_valid  output  1  one-cycle pulse when data0/data1 update.
- frame_err  output  1  one-cycle pulse on a short frame.
- busy  output  1  high while state is not IDLE.
- frame_cnt  output  16  count of good frames; wraps at 0xFFFF to 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values:
  - data0, data1, data_valid, frame_err, busy, frame_cnt = 0; state = IDLE; bit counter = 0.
  - sync synchroniser chain and its previous-value register reset to 1, so no false falling edge follows reset.
  - sclk and data chains reset to 0.
- Input synchronisation:
  - Each input passes through SYNC_STAGES flops, giving sclk_s, sync_s, d0_s, d1_s.
  - edge = registered sclk_s compared with its previous value; the direction is set by SAMPLE_FALLING.
  - sync_fall and sync_rise are detected the same way.
- Input timing requirement: sclk high and low phases each >= SYNC_STAGES+1 clk cycles. The DAC writer's 16.7 MHz sclk (6 clk cycles per phase) meets this.
- States:
  - IDLE: on sync_fall, clear shift registers and bit counter, go to SHIFT. sclk edges are ignored.
  - SHIFT, on edge while sync_s = 0:
    - shift0 <= {shift0[WORD_BITS-2:0], d0_s}; shift1 likewise; bit counter += 1.
    - On the WORD_BITS-th edge: load data0/data1 with the completed words, pulse data_valid for 1 cycle, frame_cnt += 1, go to WAIT_HIGH.
  - SHIFT, on sync_rise before WORD_BITS edges: pulse frame_err, data0/data1 unchanged, go to IDLE.
  - WAIT_HIGH: extra sclk edges are ignored. On sync_rise, go to IDLE.
- Simultaneous events:
  - sync_rise and edge in the same cycle: sync_rise wins and the edge is discarded. A frame completes only if WORD_BITS edges were already taken.
  - sync_fall while in WAIT_HIGH cannot occur without a sync_rise first; a fresh frame needs IDLE.
- Latency: data_valid asserts exactly SYNC_STAGES+2 clk cycles after the raw sclk edge carrying the last bit. The data0/data1 update lands in the same cycle.
- Back-to-back frames: sync high for >= SYNC_STAGES+1 cycles between frames is sufficient. No frame is lost.
- Reset mid-frame:
  - Returns to IDLE with outputs at reset values.
  - If sync_in is still low at reset release, no falling edge is seen. The partial frame is dropped silently (no frame_err); reception resumes at the next sync high-to-low.
- frame_err and data_valid are never high in the same cycle.

Test Plan:
- Reset, then one frame: lane0 0xA5C3, lane1 0x3C5A, sclk 6/6 cycles, falling-edge sampling -> one data_valid pulse; data0 = 0xA5C3, data1 = 0x3C5A, frame_cnt = 1, frame_err never high.
- Short frame: sync rises after 9 sclk edges -> one frame_err pulse, no data_valid, data0/data1 keep previous values, busy = 0 within SYNC_STAGES+2 cycles.
- Long frame: 20 edges with lane0 0xFFFF then 4 zero bits -> data0 = 0xFFFF, single data_valid, frame_cnt += 1, busy until sync rise.
- 3 back-to-back frames (0x0001, 0x8000, 0x1234 on lane0; complements on lane1), sync high for 3 cycles between -> three data_valid pulses with matching words, frame_cnt = 3.
- rst_n low for 2 cycles at bit 7 with sync held low, released mid-frame -> all outputs 0, no data_valid or frame_err until the next sync fall; the next full frame 0x00FF is received correctly.
- Preload frame_cnt to 0xFFFF via 65535 frames (or force), then one more good frame -> frame_cnt = 0x0000; measured latency equals SYNC_STAGES+2 for SYNC_STAGES = 2 and 3.

Source files
------------

// File: rtl/dac_frame_rx.sv
// Two-lane DAC frame receiver. It oversamples sclk, sync and both data lanes on clk,
// deserialises one word per lane per frame (MSB first), and flags short frames.
module dac_frame_rx #(
  parameter int unsigned WORD_BITS      = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter bit          SAMPLE_FALLING = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk_in,
  input  logic                 sync_in,
  input  logic                 din_in,
  input  logic                 din_1_in,
  output logic [WORD_BITS-1:0] data0,
  output logic [WORD_BITS-1:0] data1,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);

  localparam int unsigned CntW   = $clog2(WORD_BITS + 1);
  localparam int unsigned FlushW = $clog2(SYNC_STAGES + 3);
  localparam logic [CntW-1:0]   LastBit   = CntW'(WORD_BITS - 1);
  // Edge detection stays masked until the synchronisers hold real samples, so a sync
  // line that is already low at reset release never looks like a frame start.
  localparam logic [FlushW-1:0] FlushInit = FlushW'(SYNC_STAGES + 2);

  typedef enum logic [1:0] {StIdle, StShift, StWaitHigh} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sync_sync_q, d0_sync_q, d1_sync_q;
  logic                   sclk_r_q, sclk_prev_q, sync_r_q, sync_prev_q;
  logic [FlushW-1:0]      flush_q;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [WORD_BITS-1:0]   shift0_q, shift0_d, shift1_q, shift1_d;
  logic [WORD_BITS-1:0]   data0_q, data0_d, data1_q, data1_d;
  logic                   valid_q, valid_d, err_q, err_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;

  logic d0_s, d1_s, armed, sclk_edge, sync_fall, sync_rise;

  // Input synchronisers plus one registered stage and its previous value for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      sync_sync_q <= '1;
      d0_sync_q   <= '0;
      d1_sync_q   <= '0;
      sclk_r_q    <= 1'b0;
      sclk_prev_q <= 1'b0;
      sync_r_q    <= 1'b1;
      sync_prev_q <= 1'b1;
      flush_q     <= FlushInit;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      sync_sync_q <= {sync_sync_q[SYNC_STAGES-2:0], sync_in};
      d0_sync_q   <= {d0_sync_q[SYNC_STAGES-2:0], din_in};
      d1_sync_q   <= {d1_sync_q[SYNC_STAGES-2:0], din_1_in};
      sclk_r_q    <= sclk_sync_q[SYNC_STAGES-1];
      sclk_prev_q <= sclk_r_q;
      sync_r_q    <= sync_sync_q[SYNC_STAGES-1];
      sync_prev_q <= sync_r_q;
      if (flush_q != '0) begin
        flush_q <= flush_q - 1'b1;
      end
    end
  end

  // Edge strobes derived from the registered samples.
  always_comb begin
    d0_s      = d0_sync_q[SYNC_STAGES-1];
    d1_s      = d1_sync_q[SYNC_STAGES-1];
    armed     = (flush_q == '0);
    sclk_edge = armed & (SAMPLE_FALLING ? (sclk_prev_q & ~sclk_r_q)
                                        : (~sclk_prev_q & sclk_r_q));
    sync_fall = armed & sync_prev_q & ~sync_r_q;
    sync_rise = armed & ~sync_prev_q & sync_r_q;
  end

  // Frame state machine registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift0_q    <= '0;
      shift1_q    <= '0;
      data0_q     <= '0;
      data1_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift0_q    <= shift0_d;
      shift1_q    <= shift1_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state logic; sync_rise takes priority over a coincident sclk edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift0_d    = shift0_q;
    shift1_d    = shift1_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (sync_fall) begin
          shift0_d = '0;
          shift1_d = '0;
          cnt_d    = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        if (sync_rise) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (sclk_edge && !sync_r_q) begin
          shift0_d = {shift0_q[WORD_BITS-2:0], d0_s};
          shift1_d = {shift1_q[WORD_BITS-2:0], d1_s};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
            data0_d     = shift0_d;
            data1_d     = shift1_d;
            valid_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        if (sync_rise) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign data0      = data0_q;
  assign data1      = data1_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != StIdle);
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_dac_frame_rx.sv
// Directed bench for dac_frame_rx: a frame-level model predicts every data_valid /
// frame_err event and the held output values; a second instance checks latency at
// SYNC_STAGES = 3.
module tb_dac_frame_rx;

  logic        clk = 1'b0;
  logic        rst_n, sclk_in, sync_in, din_in, din_1_in;
  logic [15:0] data0, data1, frame_cnt;
  logic        data_valid, frame_err, busy;
  logic [15:0] data0_3, data1_3, frame_cnt_3;
  logic        data_valid_3, frame_err_3, busy_3;

  always #2.5 clk = ~clk;

  dac_frame_rx #(.WORD_BITS(16), .SYNC_STAGES(2), .SAMPLE_FALLING(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .sync_in(sync_in), .din_in(din_in),
    .din_1_in(din_1_in), .data0(data0), .data1(data1), .data_valid(data_valid),
    .frame_err(frame_err), .busy(busy), .frame_cnt(frame_cnt)
  );

  dac_frame_rx #(.WORD_BITS(16), .SYNC_STAGES(3), .SAMPLE_FALLING(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .sync_in(sync_in), .din_in(din_in),
    .din_1_in(din_1_in), .data0(data0_3), .data1(data1_3), .data_valid(data_valid_3),
    .frame_err(frame_err_3), .busy(busy_3), .frame_cnt(frame_cnt_3)
  );

  typedef struct {
    bit          good;
    logic [15:0] w0;
    logic [15:0] w1;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] m_d0, m_d1, m_cnt;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_edge_cyc = 0;
  int          lat2 = -1;
  int          lat3 = -1;
  logic        rst_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  // Model/compare: events in order of frames sent, outputs hold between events.
  always @(negedge clk) begin
    ev_t e;
    if (!rst_seen) begin
      m_d0  = '0;
      m_d1  = '0;
      m_cnt = '0;
    end else if (data_valid || frame_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, data_valid, frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_valid", {31'd0, data_valid}, {31'd0, e.good});
        if (e.good) begin
          m_d0  = e.w0;
          m_d1  = e.w1;
          m_cnt = m_cnt + 16'd1;
        end
      end
    end
    check("valid_and_err", {31'd0, data_valid & frame_err}, 32'd0);
    check("data0_model", {16'd0, data0}, {16'd0, m_d0});
    check("data1_model", {16'd0, data1}, {16'd0, m_d1});
    check("frame_cnt_model", {16'd0, frame_cnt}, {16'd0, m_cnt});
  end

  // Cycles from the raw sclk edge of the last bit to data_valid.
  always @(negedge clk) begin
    if (data_valid)   lat2 = cyc - last_edge_cyc;
    if (data_valid_3) lat3 = cyc - last_edge_cyc;
  end

  // One frame: sclk 6/6 cycles, data changes on rise, sampled on fall.
  task automatic send_frame(input logic [15:0] w0, input logic [15:0] w1, input int nedges,
                            input int gap, input int rst_at);
    ev_t e;
    if (rst_at < 0) begin
      e.good = (nedges >= 16);
      e.w0   = w0;
      e.w1   = w1;
      exp_q.push_back(e);
    end
    sync_in = 1'b0;
    step(6);
    for (int i = 0; i < nedges; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      din_in   = (i < 16) ? w0[15-i] : 1'b0;
      din_1_in = (i < 16) ? w1[15-i] : 1'b0;
      sclk_in  = 1'b1;
      step(6);
      sclk_in       = 1'b0;
      last_edge_cyc = cyc;
      step(6);
    end
    check("busy_before_rise", {31'd0, busy}, {31'd0, (rst_at < 0)});
    sync_in = 1'b1;
    if (gap >= 4) begin
      step(4);
      check("busy_after_rise", {31'd0, busy}, 32'd0);
      step(gap - 4);
    end else begin
      step(gap);
    end
  endtask

  initial begin
    rst_n = 1'b0; sclk_in = 1'b0; sync_in = 1'b1; din_in = 1'b0; din_1_in = 1'b0;
    step(4);
    rst_n = 1'b1;
    step(8);
    check("rst_data0", {16'd0, data0}, 32'd0);
    check("rst_data1", {16'd0, data1}, 32'd0);
    check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);

    send_frame(16'hA5C3, 16'h3C5A, 16, 10, -1);
    check("f1_data0", {16'd0, data0}, 32'h0000A5C3);
    check("f1_data1", {16'd0, data1}, 32'h00003C5A);
    check("f1_cnt", {16'd0, frame_cnt}, 32'd1);

    send_frame(16'h1234, 16'h5678, 9, 10, -1);
    check("short_data0", {16'd0, data0}, 32'h0000A5C3);
    check("short_cnt", {16'd0, frame_cnt}, 32'd1);

    send_frame(16'hFFFF, 16'h0F0F, 20, 10, -1);
    check("long_data0", {16'd0, data0}, 32'h0000FFFF);
    check("long_data1", {16'd0, data1}, 32'h00000F0F);
    check("long_cnt", {16'd0, frame_cnt}, 32'd2);

    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(8);
    send_frame(16'h0001, 16'hFFFE, 16, 3, -1);
    send_frame(16'h8000, 16'h7FFF, 16, 3, -1);
    send_frame(16'h1234, 16'hEDCB, 16, 10, -1);
    check("b2b_data0", {16'd0, data0}, 32'h00001234);
    check("b2b_data1", {16'd0, data1}, 32'h0000EDCB);
    check("b2b_cnt", {16'd0, frame_cnt}, 32'd3);

    send_frame(16'hAAAA, 16'h5555, 16, 10, 7);
    check("midrst_data0", {16'd0, data0}, 32'd0);
    check("midrst_cnt", {16'd0, frame_cnt}, 32'd0);
    send_frame(16'h00FF, 16'hFF00, 16, 10, -1);
    check("after_rst_data0", {16'd0, data0}, 32'h000000FF);
    check("after_rst_data1", {16'd0, data1}, 32'h0000FF00);
    check("after_rst_cnt", {16'd0, frame_cnt}, 32'd1);

    force dut.frame_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    step(1);
    release dut.frame_cnt_q;
    step(2);
    send_frame(16'hBEEF, 16'hCAFE, 16, 10, -1);
    check("wrap_cnt", {16'd0, frame_cnt}, 32'd0);
    check("wrap_data0", {16'd0, data0}, 32'h0000BEEF);
    check("latency_s2", lat2, 32'd4);
    check("latency_s3", lat3, 32'd5);
    check("dut3_data0", {16'd0, data0_3}, 32'h0000BEEF);

    step(20);
    check("events_outstanding", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
